// File: rtl/shift_encode_pipe.sv
// Two-stage pipelined shift/rotate followed by an MSB-first priority encoder, valid/ready both ends.
// Define SHIFT_ENC_POPCNT_EN to add the out_popcnt result port.
module shift_encode_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_shifted,
  output logic [SHW-1:0]   out_pe_idx,
  output logic             out_pe_vld
`ifdef SHIFT_ENC_POPCNT_EN
  ,
  output logic [SHW:0]     out_popcnt
`endif
);

  typedef enum logic [1:0] {
    ModeLsl = 2'b00,
    ModeLsr = 2'b01,
    ModeRol = 2'b10,
    ModeRor = 2'b11
  } mode_e;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_data_q, s1_data_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic [SHW-1:0]   s2_idx_q, s2_idx_d;
  logic             s2_pe_vld_q, s2_pe_vld_d;

  logic             s1_adv, in_fire, s2_load;
  logic [WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] dbl_l, dbl_r;
  logic [SHW-1:0]   pe_idx;

  assign s1_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s1_adv;

  // Rotates come from a doubled word so a shamt of 0 never needs a shift by WIDTH.
  always_comb begin
    dbl_l   = {in_data, in_data} << in_shamt;
    dbl_r   = {in_data, in_data} >> in_shamt;
    shifted = in_data;
    unique case (mode_e'(in_mode))
      ModeLsl: shifted = in_data << in_shamt;
      ModeLsr: shifted = in_data >> in_shamt;
      ModeRol: shifted = dbl_l[2*WIDTH-1:WIDTH];
      ModeRor: shifted = dbl_r[WIDTH-1:0];
    endcase
  end

  // Ascending scan: the last set bit seen is the highest, giving MSB-first priority.
  always_comb begin
    pe_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s1_data_q[i]) pe_idx = SHW'(i);
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_idx_d    = s2_idx_q;
    s2_pe_vld_d = s2_pe_vld_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_data_d  = shifted;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s2_load) begin
      s2_valid_d  = 1'b1;
      s2_data_d   = s1_data_q;
      s2_idx_d    = pe_idx;
      s2_pe_vld_d = |s1_data_q;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_idx_q    <= '0;
      s2_pe_vld_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_idx_q    <= s2_idx_d;
      s2_pe_vld_q <= s2_pe_vld_d;
    end
  end

  assign out_valid   = s2_valid_q;
  assign out_shifted = s2_data_q;
  assign out_pe_idx  = s2_idx_q;
  assign out_pe_vld  = s2_pe_vld_q;

`ifdef SHIFT_ENC_POPCNT_EN
  logic [SHW:0] popcnt, s2_popcnt_q;

  always_comb begin
    popcnt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      popcnt = popcnt + (SHW+1)'(s1_data_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_popcnt_q <= '0;
    end else if (s2_load) begin
      s2_popcnt_q <= popcnt;
    end
  end

  assign out_popcnt = s2_popcnt_q;
`endif

endmodule

// File: tb/tb_shift_encode_pipe.sv
// Directed and random-stream bench for shift_encode_pipe (WIDTH=8).
// Popcount checks are compiled in when SHIFT_ENC_POPCNT_EN is defined.
module tb_shift_encode_pipe;

  localparam logic [1:0] LSL = 2'b00, LSR = 2'b01, ROL = 2'b10, ROR = 2'b11;

  logic       clk, rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_shifted;
  logic [2:0] in_shamt, out_pe_idx;
  logic [1:0] in_mode;
  logic       out_pe_vld;
`ifdef SHIFT_ENC_POPCNT_EN
  logic [3:0] out_popcnt;
  logic [3:0] last_pc;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_in, n_out, src_i, src_n;
  bit want_valid, want_ready, use_model;
  logic [7:0]  src_d [64];
  logic [2:0]  src_s [64];
  logic [1:0]  src_m [64];
  logic [11:0] exp_q [$];

  shift_encode_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_shamt    (in_shamt),
    .in_mode     (in_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_shifted (out_shifted),
    .out_pe_idx  (out_pe_idx),
    .out_pe_vld  (out_pe_vld)
`ifdef SHIFT_ENC_POPCNT_EN
    ,
    .out_popcnt  (out_popcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Bit-serial reference: one position per iteration, then a downward search for the top bit.
  function automatic logic [11:0] model(input logic [7:0] d, input logic [2:0] s,
                                        input logic [1:0] m);
    logic [7:0] r;
    logic [2:0] idx;
    logic       found;
    r = d;
    for (int i = 0; i < int'(s); i++) begin
      case (m)
        LSL:     r = {r[6:0], 1'b0};
        LSR:     r = {1'b0, r[7:1]};
        ROL:     r = {r[6:0], r[7]};
        default: r = {r[0], r[7:1]};
      endcase
    end
    idx   = 3'd0;
    found = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (r[i] && !found) begin
        idx   = 3'(i);
        found = 1'b1;
      end
    end
    return {found, idx, r};
  endfunction

  task automatic one_beat(input string tag, input logic [7:0] d, input logic [2:0] s,
                          input logic [1:0] m, input logic [7:0] ed, input logic [2:0] ei,
                          input logic ev);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_lat2"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_shifted), 32'(ed));
    check({tag, "_idx"}, 32'(out_pe_idx), 32'(ei));
    check({tag, "_vld"}, 32'(out_pe_vld), 32'(ev));
`ifdef SHIFT_ENC_POPCNT_EN
    last_pc = out_popcnt;
`endif
  endtask

  task automatic drive_in();
    in_valid = want_valid && (src_i < src_n);
    if (src_i < src_n) begin
      in_data  = src_d[src_i];
      in_shamt = src_s[src_i];
      in_mode  = src_m[src_i];
    end
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check({tag, "_extra"}, 32'(n_out + 1), 32'(n_in));
      else check(tag, 32'({out_pe_vld, out_pe_idx, out_shifted}), 32'(exp_q.pop_front()));
      n_out++;
    end
    if (in_valid && in_ready) begin
      if (use_model) exp_q.push_back(model(in_data, in_shamt, in_mode));
      n_in++;
      src_i++;
    end
    @(posedge clk); #1;
    out_ready = want_ready;
    drive_in();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
    out_ready = 1'b1;
    #3;
    check("rst0_ovld", 32'(out_valid), 32'd0);
    check("rst0_data", 32'(out_shifted), 32'd0);
    check("rst0_idx", 32'(out_pe_idx), 32'd0);
    check("rst0_pevld", 32'(out_pe_vld), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst0_irdy", 32'(in_ready), 32'd1);

    // Reset with two beats in flight
    in_valid = 1'b1; in_data = 8'hB4; in_shamt = 3'd3; in_mode = ROL;
    @(posedge clk); #1;
    in_data = 8'h80; in_shamt = 3'd7; in_mode = LSR;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst1_pre_vld", 32'(out_valid), 32'd1);
    check("rst1_pre_data", 32'(out_shifted), 32'hA5);
    #2 rst_n = 1'b0;
    #1;
    check("rst1_ovld", 32'(out_valid), 32'd0);
    check("rst1_data", 32'(out_shifted), 32'd0);
    check("rst1_idx", 32'(out_pe_idx), 32'd0);
    check("rst1_pevld", 32'(out_pe_vld), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst1_irdy", 32'(in_ready), 32'd1);
    check("rst1_drop_a", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("rst1_drop_b", 32'(out_valid), 32'd0);

    // Modes
    one_beat("rol", 8'hB4, 3'd3, ROL, 8'hA5, 3'd7, 1'b1);
`ifdef SHIFT_ENC_POPCNT_EN
    check("pc_a5", 32'(last_pc), 32'd4);
`endif
    one_beat("lsr", 8'h80, 3'd7, LSR, 8'h01, 3'd0, 1'b1);
    one_beat("lsl", 8'h81, 3'd7, LSL, 8'h80, 3'd7, 1'b1);
    one_beat("ror", 8'h01, 3'd1, ROR, 8'h80, 3'd7, 1'b1);
    one_beat("z_lsl", 8'h5A, 3'd0, LSL, 8'h5A, 3'd6, 1'b1);
    one_beat("z_lsr", 8'h5A, 3'd0, LSR, 8'h5A, 3'd6, 1'b1);
    one_beat("z_rol", 8'h5A, 3'd0, ROL, 8'h5A, 3'd6, 1'b1);
    one_beat("z_ror", 8'h5A, 3'd0, ROR, 8'h5A, 3'd6, 1'b1);

    // Zero result
    one_beat("f0", 8'h0F, 3'd4, LSL, 8'hF0, 3'd7, 1'b1);
    one_beat("zero", 8'h0F, 3'd4, LSR, 8'h00, 3'd0, 1'b0);
`ifdef SHIFT_ENC_POPCNT_EN
    check("pc_zero", 32'(last_pc), 32'd0);
    one_beat("ff", 8'hFF, 3'd0, ROL, 8'hFF, 3'd7, 1'b1);
    check("pc_ff", 32'(last_pc), 32'd8);
`endif

    // Backpressure: three beats offered into a stalled pipe
    src_d[0] = 8'h12; src_s[0] = 3'd1; src_m[0] = LSL;
    src_d[1] = 8'h81; src_s[1] = 3'd1; src_m[1] = ROR;
    src_d[2] = 8'hF0; src_s[2] = 3'd4; src_m[2] = LSR;
    exp_q.delete();
    exp_q.push_back({1'b1, 3'd5, 8'h24});
    exp_q.push_back({1'b1, 3'd7, 8'hC0});
    exp_q.push_back({1'b1, 3'd3, 8'h0F});
    n_in = 0; n_out = 0; src_i = 0; src_n = 3; use_model = 1'b0;
    want_valid = 1'b1; want_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_in();
    repeat (5) step("bp");
    @(negedge clk);
    check("bp_accepted", 32'(n_in), 32'd2);
    check("bp_irdy", 32'(in_ready), 32'd0);
    check("bp_ovld", 32'(out_valid), 32'd1);
    check("bp_hold_a", 32'({out_pe_vld, out_pe_idx, out_shifted}), 32'h0D24);
    @(posedge clk);
    @(negedge clk);
    check("bp_hold_b", 32'({out_pe_vld, out_pe_idx, out_shifted}), 32'h0D24);
    check("bp_irdy_b", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    want_ready = 1'b1;
    out_ready  = 1'b1;
    for (int c = 0; c < 20 && n_out < 3; c++) step("bp_out");
    check("bp_nout", 32'(n_out), 32'd3);
    check("bp_nin", 32'(n_in), 32'd3);
    check("bp_left", 32'(exp_q.size()), 32'd0);

    // Random streaming against the reference model
    for (int i = 0; i < 50; i++) begin
      src_d[i] = 8'($urandom);
      src_s[i] = 3'($urandom_range(7));
      src_m[i] = 2'($urandom_range(3));
    end
    exp_q.delete();
    n_in = 0; n_out = 0; src_i = 0; src_n = 50; use_model = 1'b1;
    want_valid = 1'b1; want_ready = 1'b1;
    drive_in();
    for (int c = 0; c < 2000 && n_out < 50; c++) begin
      want_valid = ($urandom_range(3) != 0);
      want_ready = ($urandom_range(2) != 0);
      step("stream");
    end
    check("stream_nin", 32'(n_in), 32'd50);
    check("stream_nout", 32'(n_out), 32'd50);
    check("stream_left", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
